// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, the data (MEM stage) port and the memory bus
// of mem_port_arbiter.
//   fetch : if_req/if_addr in, if_ack/if_rdata/if_fault out
//   data  : dm_req/dm_we/dm_addr/dm_wdata in, dm_ack/dm_rdata/dm_fault out
//   memory: mem_we/mem_ma/mem_addr/mem_wdata out, mem_rdata in
// Modport slave is the arbiter; modport master is its environment
// (requesters plus the memory device).
// Handshake: a requester raises req with its address/data and holds them
// until it sees its ack, which is a one-cycle pulse; rdata/fault are only
// meaningful while ack is high. The requester drops req in the ack cycle.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_fault;

  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_fault;

  logic        mem_we;
  logic        mem_ma;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, if_fault, dm_ack, dm_rdata, dm_fault,
           mem_we, mem_ma, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, if_fault, dm_ack, dm_rdata, dm_fault,
           mem_we, mem_ma, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the shared edge-triggered memory (ROM 0x0000-0x001F, RAM
// 0x0800-0x083F) between instruction fetch (read-only) and the MEM stage
// (read/write), and generates the setup / strobe / settle timing the memory
// needs. Data wins over fetch unless fetch has been passed over STARVE_MAX
// times in a row. Bad addresses and ROM writes fault without touching memory.
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   bus         mem_port_arbiter_if.slave (fetch, data and memory signals)
//   o_dbg_state current FSM state (0 IDLE,1 SETUP,2 STROBE,3 WAIT,4 DONE)
// All outputs are registered: the output process computes next-cycle values
// from the next state, and they are flopped.
module mem_port_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int WAIT_CYC   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus,
  output logic [2:0]          o_dbg_state
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_cnt;      // cycles spent in the current state
  logic          r_id;       // latched winner: 1 = fetch, 0 = data
  logic          r_we;       // latched write flag
  logic [SW-1:0] r_starve;

  logic          w_grant, w_grant_if, w_g_we, w_g_fault;
  logic [15:0]   w_g_addr;
  logic          w_id_d, w_done_d, w_fault_d;
  logic          w_if_ack_d, w_dm_ack_d, w_mem_we_d, w_mem_ma_d;
  logic [31:0]   w_rdata_d;

  function automatic logic addr_fault(input logic [15:0] a, input logic we);
    logic rom, ram;
    rom = (a <= 16'h001F);
    ram = (a >= 16'h0800) && (a <= 16'h083F);
    return !(rom || ram) || (rom && we);
  endfunction

  // Grant decision, only acted on in IDLE. Fetch wins when data is idle or
  // when fetch has been starved for STARVE_MAX consecutive data grants.
  always_comb begin
    w_grant    = bus.if_req || bus.dm_req;
    w_grant_if = bus.if_req && (!bus.dm_req || (r_starve == SW'(STARVE_MAX)));
    w_g_addr   = w_grant_if ? bus.if_addr : bus.dm_addr;
    w_g_we     = w_grant_if ? 1'b0 : bus.dm_we;
    w_g_fault  = addr_fault(w_g_addr, w_g_we);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = w_g_fault ? S_DONE : S_SETUP;
      S_SETUP:  if (r_cnt == 8'(SETUP_CYC - 1))  w_next = S_STROBE;
      S_STROBE: if (r_cnt == 8'(STROBE_CYC - 1)) w_next = S_WAIT;
      S_WAIT:   if (r_cnt == 8'(WAIT_CYC - 1))   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic (values registered below). In IDLE the winner is not yet
  // latched, so the grant signals stand in for r_id/r_we.
  always_comb begin
    w_id_d     = (r_state == S_IDLE) ? w_grant_if : r_id;
    w_done_d   = (w_next == S_DONE);
    w_fault_d  = (r_state == S_IDLE) && w_g_fault;
    w_rdata_d  = (w_done_d && (r_state == S_WAIT) && !r_we) ? bus.mem_rdata : 32'd0;
    w_if_ack_d = w_done_d && w_id_d;
    w_dm_ack_d = w_done_d && !w_id_d;
    w_mem_we_d = (w_next == S_STROBE) && r_we;
    w_mem_ma_d = (w_next == S_STROBE) && !r_we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.if_ack   <= 1'b0;
      bus.if_rdata <= '0;
      bus.if_fault <= 1'b0;
      bus.dm_ack   <= 1'b0;
      bus.dm_rdata <= '0;
      bus.dm_fault <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_ma   <= 1'b0;
    end else begin
      bus.if_ack   <= w_if_ack_d;
      bus.if_rdata <= w_if_ack_d ? w_rdata_d : 32'd0;
      bus.if_fault <= w_if_ack_d && w_fault_d;
      bus.dm_ack   <= w_dm_ack_d;
      bus.dm_rdata <= w_dm_ack_d ? w_rdata_d : 32'd0;
      bus.dm_fault <= w_dm_ack_d && w_fault_d;
      bus.mem_we   <= w_mem_we_d;
      bus.mem_ma   <= w_mem_ma_d;
    end
  end

  // Request latch, memory address/data and starve counter. mem_addr and
  // mem_wdata load only on a non-faulting grant so they hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_id          <= 1'b0;
      r_we          <= 1'b0;
      r_starve      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_grant) begin
        r_id <= w_grant_if;
        r_we <= w_g_we;
        if (!w_g_fault) begin
          bus.mem_addr  <= w_g_addr;
          bus.mem_wdata <= w_grant_if ? 32'd0 : bus.dm_wdata;
        end
      end
      if (w_grant_if || !bus.if_req)
        r_starve <= '0;
      else if (bus.dm_req && (r_starve != SW'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;
    end
  end

  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural memory device, a reference
// model of decode/latency/arbitration, and per-scenario test tasks.
module tb_mem_port_arbiter;
  localparam int SETUP_CYC  = 1;
  localparam int STROBE_CYC = 1;
  localparam int WAIT_CYC   = 2;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC),
    .WAIT_CYC(WAIT_CYC), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- memory device ----------------
  logic [31:0] dev_ram [64];
  logic [31:0] ref_ram [64];

  function automatic logic [31:0] rom_word(input int i);
    if (i == 28) return 32'h0000_0810;
    return 32'h1000_0000 | (i * 32'h0000_0101);
  endfunction

  initial bus.mem_rdata = 32'd0;

  always @(posedge bus.mem_ma) begin
    if (bus.mem_addr < 16'd32)
      bus.mem_rdata <= rom_word(int'(bus.mem_addr));
    else if (bus.mem_addr >= 16'h0800 && bus.mem_addr < 16'h0840)
      bus.mem_rdata <= dev_ram[bus.mem_addr - 16'h0800];
    else
      bus.mem_rdata <= 32'hBAD0_BAD0;
  end

  always @(posedge bus.mem_we) begin
    if (bus.mem_addr >= 16'h0800 && bus.mem_addr < 16'h0840)
      dev_ram[bus.mem_addr - 16'h0800] <= bus.mem_wdata;
  end

  // ---------------- reference model ----------------
  function automatic bit ref_fault(input int a, input bit we);
    bit in_rom, in_ram;
    in_rom = (a < 32);
    in_ram = (a >= 2048) && (a < 2048 + 64);
    return !(in_rom || in_ram) || (in_rom && we);
  endfunction

  function automatic logic [31:0] ref_read(input int a);
    if (a < 32) return rom_word(a);
    return ref_ram[a - 2048];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
  endtask

  // One isolated request; checks latency, response and strobe behaviour.
  task automatic run_txn(input bit is_if, input bit we_in, input logic [15:0] addr,
                         input logic [31:0] wdata, input string name);
    bit we, exp_fault, seen, other_ack, both, addr_bad, wdata_bad;
    logic [31:0] exp_rdata, got_rdata;
    logic got_fault;
    int exp_lat, lat, ma_cnt, we_cnt, first_strobe, exp_ma, exp_we;
    we = is_if ? 1'b0 : we_in;
    exp_fault = ref_fault(int'(addr), we);
    exp_rdata = (exp_fault || we) ? 32'd0 : ref_read(int'(addr));
    exp_lat = exp_fault ? 1 : 1 + SETUP_CYC + STROBE_CYC + WAIT_CYC;
    seen = 0; other_ack = 0; both = 0; addr_bad = 0; wdata_bad = 0;
    lat = 0; ma_cnt = 0; we_cnt = 0; first_strobe = 0;
    got_rdata = '0; got_fault = 1'b0;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.mem_ma && bus.mem_we) both = 1;
      if (bus.mem_ma || bus.mem_we) begin
        if (first_strobe == 0) first_strobe = c;
        if (bus.mem_addr !== addr) addr_bad = 1;
        if (bus.mem_we && bus.mem_wdata !== wdata) wdata_bad = 1;
      end
      if (bus.mem_ma) ma_cnt++;
      if (bus.mem_we) we_cnt++;
      if (is_if ? bus.dm_ack : bus.if_ack) other_ack = 1;
      if (is_if ? bus.if_ack : bus.dm_ack) begin
        seen = 1; lat = c;
        got_rdata = is_if ? bus.if_rdata : bus.dm_rdata;
        got_fault = is_if ? bus.if_fault : bus.dm_fault;
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL %s ack: never seen within 40 cycles", name);
    end else begin
      if (lat !== exp_lat) begin
        n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      n_vec++;
      if (got_rdata !== exp_rdata) begin
        n_err++; $display("FAIL %s rdata: got %h want %h", name, got_rdata, exp_rdata);
      end
      n_vec++;
      if (got_fault !== exp_fault) begin
        n_err++; $display("FAIL %s fault: got %0b want %0b", name, got_fault, exp_fault);
      end
    end
    exp_ma = (!exp_fault && !we) ? STROBE_CYC : 0;
    exp_we = (!exp_fault && we) ? STROBE_CYC : 0;
    n_vec++;
    if (ma_cnt != exp_ma || we_cnt != exp_we || both) begin
      n_err++;
      $display("FAIL %s strobes: ma=%0d we=%0d both=%0b want ma=%0d we=%0d",
               name, ma_cnt, we_cnt, both, exp_ma, exp_we);
    end
    if (!exp_fault) begin
      n_vec++;
      if (first_strobe != SETUP_CYC + 1 || addr_bad || wdata_bad) begin
        n_err++;
        $display("FAIL %s strobe_timing: first=%0d addr_bad=%0b wdata_bad=%0b want first=%0d",
                 name, first_strobe, addr_bad, wdata_bad, SETUP_CYC + 1);
      end
    end
    n_vec++;
    if (bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 || other_ack) begin
      n_err++;
      $display("FAIL %s ack_pulse: if_ack=%0b dm_ack=%0b other_ack=%0b want 0 0 0",
               name, bus.if_ack, bus.dm_ack, other_ack);
    end
    if (!exp_fault && we) ref_ram[addr - 16'h0800] = wdata;
  endtask

  // Both requesters active. Expected grant order comes from exp_q
  // ({id, rdata}, id 1 = fetch). hold=1 keeps both reqs high throughout.
  logic [32:0] exp_q [$];

  task automatic run_stream(input bit hold, input string name);
    logic [32:0] e;
    bit prev_ack;
    int budget;
    prev_ack = 0;
    budget = 300;
    bus.if_req = 1'b1; bus.if_addr = 16'h0003;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0812;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (bus.if_ack && bus.dm_ack) begin
        n_vec++; n_err++;
        $display("FAIL %s overlap: if_ack=1 dm_ack=1 want one-hot", name);
      end
      if (bus.if_ack || bus.dm_ack) begin
        e = exp_q.pop_front();
        n_vec++;
        if (prev_ack) begin
          n_err++; $display("FAIL %s ack_width: ack high on consecutive cycles", name);
        end
        n_vec++;
        if (bus.if_ack !== e[32]) begin
          n_err++; $display("FAIL %s grant: got if_ack=%0b want %0b", name, bus.if_ack, e[32]);
        end
        n_vec++;
        if ((bus.if_ack ? bus.if_rdata : bus.dm_rdata) !== e[31:0]) begin
          n_err++;
          $display("FAIL %s rdata: got %h want %h", name,
                   bus.if_ack ? bus.if_rdata : bus.dm_rdata, e[31:0]);
        end
        if (!hold) begin
          if (bus.if_ack) bus.if_req = 1'b0;
          if (bus.dm_ack) bus.dm_req = 1'b0;
        end
        prev_ack = 1;
      end else begin
        prev_ack = 0;
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s timeout: %0d acks missing", name, exp_q.size());
      exp_q.delete();
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.if_ack, bus.if_fault, bus.dm_ack, bus.dm_fault, bus.mem_we, bus.mem_ma} !== 6'd0 ||
        bus.if_rdata !== 32'd0 || bus.dm_rdata !== 32'd0 ||
        bus.mem_addr !== 16'd0 || bus.mem_wdata !== 32'd0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_outputs: state=%0d mem_addr=%h mem_we=%0b mem_ma=%0b want all 0",
               dbg_state, bus.mem_addr, bus.mem_we, bus.mem_ma);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_rom();
    run_txn(1'b1, 1'b0, 16'h001C, 32'd0, "fetch_rom_1c");
    run_txn(1'b1, 1'b0, 16'h0000, 32'd0, "fetch_rom_00");
    run_txn(1'b1, 1'b0, 16'h001F, 32'd0, "fetch_rom_1f");
  endtask

  task automatic test_dm_write_read();
    run_txn(1'b0, 1'b1, 16'h0805, 32'hDEADBEEF, "dm_write_0805");
    run_txn(1'b0, 1'b0, 16'h0805, 32'd0, "dm_read_0805");
    run_txn(1'b0, 1'b1, 16'h083F, 32'h1234_5678, "dm_write_083f");
    run_txn(1'b0, 1'b0, 16'h083F, 32'd0, "dm_read_083f");
    run_txn(1'b1, 1'b0, 16'h0800, 32'd0, "fetch_ram_0800");
  endtask

  task automatic test_faults();
    run_txn(1'b0, 1'b1, 16'h0010, 32'hCAFE_F00D, "dm_write_rom");
    run_txn(1'b1, 1'b0, 16'h0400, 32'd0, "fetch_0400");
    run_txn(1'b0, 1'b0, 16'h0020, 32'd0, "dm_read_0020");
    run_txn(1'b0, 1'b0, 16'h07FF, 32'd0, "dm_read_07ff");
    run_txn(1'b0, 1'b1, 16'h0840, 32'h5555_AAAA, "dm_write_0840");
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 31));
        1: a = 16'h0800 + 16'($urandom_range(0, 63));
        2: a = 16'($urandom_range(0, 1)) ? 16'h0840 : 16'h0020;
        default: a = 16'($urandom_range(0, 65535));
      endcase
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, "random");
    end
  endtask

  // Both held: the starve rule yields STARVE_MAX data grants, then fetch.
  task automatic test_back_to_back();
    int starve;
    starve = 0;
    for (int i = 0; i < 2 * (STARVE_MAX + 1); i++) begin
      if (starve == STARVE_MAX) begin
        exp_q.push_back({1'b1, ref_read(16'h0003)});
        starve = 0;
      end else begin
        exp_q.push_back({1'b0, ref_read(16'h0812)});
        starve++;
      end
    end
    run_stream(1'b1, "back_to_back");
  endtask

  task automatic test_simultaneous();
    exp_q.push_back({1'b0, ref_read(16'h0812)});
    exp_q.push_back({1'b1, ref_read(16'h0003)});
    run_stream(1'b0, "simultaneous");
  endtask

  task automatic test_reset_mid_strobe();
    bit hit, saw_ack;
    hit = 0; saw_ack = 0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0810; bus.dm_wdata = 32'hA1B2_C3D4;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      if (bus.mem_we) hit = 1;
    end
    n_vec++;
    if (!hit) begin
      n_err++; $display("FAIL reset_mid_strobe: mem_we never rose within 20 cycles");
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_we !== 1'b0 || bus.mem_ma !== 1'b0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_strobe_drop: mem_we=%0b mem_ma=%0b state=%0d want 0 0 0",
               bus.mem_we, bus.mem_ma, dbg_state);
    end
    idle_inputs();
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.dm_ack || bus.if_ack) saw_ack = 1;
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    if (bus.dm_ack || bus.if_ack) saw_ack = 1;
    n_vec++;
    if (saw_ack || dbg_state !== 3'd0 || bus.mem_addr !== 16'd0 || bus.dm_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_recover: ack=%0b state=%0d mem_addr=%h want 0 0 0000",
               saw_ack, dbg_state, bus.mem_addr);
    end
    run_txn(1'b0, 1'b1, 16'h0810, 32'hA1B2_C3D4, "reissue_write");
    run_txn(1'b0, 1'b0, 16'h0810, 32'd0, "reissue_read");
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    for (int i = 0; i < 64; i++) begin
      dev_ram[i] = $urandom;
      ref_ram[i] = dev_ram[i];
    end
    idle_inputs();
    test_reset();
    test_fetch_rom();
    test_dm_write_read();
    test_faults();
    test_random();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so a stuck DUT can never hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
